// File: rtl/haze_pkg.sv
// Shared types and constants for the haze-cpu writeback stage.
package haze_pkg;

    // Result source selector; encoding 2'd3 is reserved and handled as ALU.
    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_LINK = 2'd2
    } result_sel_t;

    // Load funct3 encodings.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Writeback FSM states.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_WRITE    = 2'd2
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment and sign/zero extension with fault detection.
module load_extend
    import haze_pkg::*;
(
    input  logic [31:0] i_Word,
    input  logic [2:0]  i_Funct3,
    input  logic [1:0]  i_Offset,
    output logic [31:0] o_Data,
    output logic        o_Fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword out of the word.
    always_comb begin
        w_byte = 8'h00;
        case (i_Offset)
            2'd0:    w_byte = i_Word[7:0];
            2'd1:    w_byte = i_Word[15:8];
            2'd2:    w_byte = i_Word[23:16];
            default: w_byte = i_Word[31:24];
        endcase
        w_half = i_Offset[1] ? i_Word[31:16] : i_Word[15:0];
    end

    // Extend per load type; misaligned or illegal loads yield zero data and a fault.
    always_comb begin
        o_Data  = '0;
        o_Fault = 1'b0;
        case (i_Funct3)
            F3_LB:  o_Data = {{24{w_byte[7]}}, w_byte};
            F3_LBU: o_Data = {24'h000000, w_byte};
            F3_LH: begin
                if (i_Offset[0]) o_Fault = 1'b1;
                else             o_Data  = {{16{w_half[15]}}, w_half};
            end
            F3_LHU: begin
                if (i_Offset[0]) o_Fault = 1'b1;
                else             o_Data  = {16'h0000, w_half};
            end
            F3_LW: begin
                if (i_Offset != 2'd0) o_Fault = 1'b1;
                else                  o_Data  = i_Word;
            end
            default: o_Fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: accepts retiring instructions, waits for load data,
// and drives the register file write port and hazard-unit forwarding info.
module writeback_stage
    import haze_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [REG_AW-1:0] i_RD,
    input  logic              i_RegWrite,
    input  logic [1:0]        i_ResultSel,
    input  logic [XLEN-1:0]   i_ALUResult,
    input  logic [XLEN-1:0]   i_LinkAddr,
    input  logic [2:0]        i_LoadFunct3,
    input  logic [1:0]        i_ByteOffset,
    input  logic              i_MemRespValid,
    input  logic [XLEN-1:0]   i_MemRespData,
    output logic [REG_AW-1:0] o_RD,
    output logic              o_WriteEnable,
    output logic [XLEN-1:0]   o_D,
    output logic              o_FwdPending,
    output logic [REG_AW-1:0] o_FwdRD,
    output logic              o_Retire,
    output logic              o_LoadFault
);

    wb_state_t         r_state;
    wb_state_t         w_next;

    // Holding registers for the instruction in flight.
    logic [REG_AW-1:0] r_rd;
    logic              r_regwrite;
    logic [2:0]        r_funct3;
    logic [1:0]        r_offset;

    // Registered write-port / status outputs, valid while in S_WRITE.
    logic [REG_AW-1:0] r_out_rd;
    logic              r_out_we;
    logic [XLEN-1:0]   r_out_d;
    logic              r_out_retire;
    logic              r_out_fault;

    logic              w_accept;
    logic              w_is_load;
    logic              w_resp;
    logic [XLEN-1:0]   w_ext_data;
    logic              w_ext_fault;

    logic [REG_AW-1:0] w_out_rd;
    logic              w_out_we;
    logic [XLEN-1:0]   w_out_d;
    logic              w_out_retire;
    logic              w_out_fault;

    load_extend u_load_extend (
        .i_Word   (i_MemRespData),
        .i_Funct3 (r_funct3),
        .i_Offset (r_offset),
        .o_Data   (w_ext_data),
        .o_Fault  (w_ext_fault)
    );

    assign o_Ready   = (r_state == S_IDLE) || (r_state == S_WRITE);
    assign w_accept  = i_Valid && o_Ready;
    assign w_is_load = (i_ResultSel == RES_LOAD);
    assign w_resp    = (r_state == S_WAIT_MEM) && i_MemRespValid;

    // Next-state logic; an accept in S_WRITE chains straight into the new instruction.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = w_is_load ? S_WAIT_MEM : S_WRITE;
            end
            S_WAIT_MEM: begin
                if (i_MemRespValid) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (w_accept) w_next = w_is_load ? S_WAIT_MEM : S_WRITE;
                else          w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Next values of the write-port outputs: set on a non-load accept or a load response.
    always_comb begin
        w_out_rd     = r_out_rd;
        w_out_we     = 1'b0;
        w_out_d      = '0;
        w_out_retire = 1'b0;
        w_out_fault  = 1'b0;
        if (w_accept && !w_is_load) begin
            w_out_rd     = i_RD;
            w_out_we     = i_RegWrite && (i_RD != '0);
            w_out_d      = (i_ResultSel == RES_LINK) ? i_LinkAddr : i_ALUResult;
            w_out_retire = 1'b1;
        end else if (w_resp) begin
            w_out_rd     = r_rd;
            w_out_we     = r_regwrite && (r_rd != '0) && !w_ext_fault;
            w_out_d      = w_ext_data;
            w_out_retire = 1'b1;
            w_out_fault  = w_ext_fault;
        end
    end

    // State, holding and output registers.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            r_state      <= S_IDLE;
            r_rd         <= '0;
            r_regwrite   <= 1'b0;
            r_funct3     <= '0;
            r_offset     <= '0;
            r_out_rd     <= '0;
            r_out_we     <= 1'b0;
            r_out_d      <= '0;
            r_out_retire <= 1'b0;
            r_out_fault  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_out_rd     <= w_out_rd;
            r_out_we     <= w_out_we;
            r_out_d      <= w_out_d;
            r_out_retire <= w_out_retire;
            r_out_fault  <= w_out_fault;
            if (w_accept) begin
                r_rd       <= i_RD;
                r_regwrite <= i_RegWrite;
                r_funct3   <= i_LoadFunct3;
                r_offset   <= i_ByteOffset;
            end
        end
    end

    assign o_RD          = r_out_rd;
    assign o_WriteEnable = r_out_we;
    assign o_D           = r_out_d;
    assign o_Retire      = r_out_retire;
    assign o_LoadFault   = r_out_fault;
    assign o_FwdPending  = (r_state == S_WAIT_MEM) && r_regwrite && (r_rd != '0);
    assign o_FwdRD       = r_rd;

endmodule
